rf_port_arbiter: RTL
====================

// Module: rf_port_arbiter
// PURPOSE
//  Shares the 4x16 register file (1 write port, 2 read ports) between two requesters.
//  Grants the single write port round-robin, routes reads to the RF read ports and returns registered responses.
//  Includes a CLEAR sequencer that zero-writes every register.
//  Sits between requester blocks and the RF instance.
// PARAMETERS
//  WORD_SIZE  16  data width of every register and data bus
//  NUM_REG    4   register count; ADDR_W = $clog2(NUM_REG) = 2
// PORTS
//  clk            in   1          single clock; all state updates on posedge
//  reset          in   1          asynchronous, active-high reset
//  req{0,1}_valid in   1          request present
//  req{0,1}_ready out  1          request accepted this cycle when valid&&ready
//  req{0,1}_we    in   1          1 = write, 0 = read
//  req{0,1}_addr  in   ADDR_W     register index
//  req{0,1}_wdata in   WORD_SIZE  write data
//  rsp{0,1}_valid out  1          one-cycle response pulse
//  rsp{0,1}_rdata out  WORD_SIZE  read data, or write data echoed on a write ack
//  clr_start      in   1          start CLEAR sweep (level sampled in RUN only)
//  clr_busy       out  1          CLEAR in progress
//  rf_write       out  1          RF write enable
//  rf_addr1       out  ADDR_W     RF read port 1 address = req0_addr
//  rf_addr2       out  ADDR_W     RF read port 2 address = req1_addr
//  rf_addr3       out  ADDR_W     RF write address
//  rf_data1       in   WORD_SIZE  RF read port 1 data (combinational in RF)
//  rf_data2       in   WORD_SIZE  RF read port 2 data
//  rf_data3       out  WORD_SIZE  RF write data
// BEHAVIOUR
//  Reset values
//  - reset=1 forces all registered state immediately: state=RUN, prio=0, clr_cnt=0, rsp*_valid=0, rsp*_rdata=0.
//  - Consequently clr_busy=0, rf_write=0, rf_addr3=0, rf_data3=0 while reset is high.
//  States
//  - RUN: serve requests. RUN->CLEAR when clr_start=1.
//  - CLEAR: lasts NUM_REG cycles. CLEAR->RUN after clr_cnt==NUM_REG-1. clr_start is ignored in CLEAR.
//  Handshake
//  - ready is combinational from both valids/we and prio.
//  - valid must not depend on ready; an unaccepted request holds all of its fields stable.
//  Reads (RUN)
//  - Both reads are always accepted (ready=1): req0 uses port 1, req1 uses port 2.
//  - rsp_valid pulses the cycle after acceptance; rsp_rdata = rf_dataN sampled at the accepting edge.
//  Writes (RUN)
//  - Uncontested write: ready=1. rf_write=1, rf_addr3/rf_data3 from that requester. The RF updates at the same edge.
//  - Contested write (both valid&&we): requester==prio wins; the loser sees ready=0; prio toggles after the grant.
//  - An uncontested grant leaves prio unchanged.
//  - Write ack: rsp_valid pulse next cycle; rsp_rdata = wdata.
//  - No write granted: rf_write=0, rf_addr3=0, rf_data3=0.
//  Same-cycle write and read of the same register
//  - Without the option below, the read returns the pre-write value.
//  clr_start cycle
//  - Requests accepted in the clr_start cycle complete normally; CLEAR begins next cycle.
//  CLEAR
//  - Both ready=0, clr_busy=1, rf_write=1, rf_addr3=clr_cnt, rf_data3=0.
//  - clr_cnt increments each cycle and returns to 0 on exit. No rsp pulses are generated.
//  Reset mid-operation
//  - Reset mid-CLEAR aborts the sweep: clr_busy drops immediately.
//  - A pending rsp pulse is discarded.
// CONFIGURATION
//  RF_ARB_FWD_EN defined
//  - A read whose addr equals the granted write addr in the same cycle returns the write data (forwarded).
//  - This applies to both requesters.
//  RF_ARB_FWD_EN undefined
//  - The read returns the RF's old value; no forwarding mux is built.
// STRUCTURE
//  Package rf_arb_pkg
//  - WORD_SIZE, NUM_REG, ADDR_W constants
//  - typedef enum {ST_RUN, ST_CLEAR} arb_state_t
//  - typedef logic [ADDR_W-1:0] reg_idx_t
//  Sub-module rf_arb_rr_pick
//  - 2-way round-robin write grant: inputs want[1:0], prio; outputs gnt[1:0], prio_next.
//  The RF itself stays external; the arbiter owns no register storage.
// TESTING
//  1. Assert reset 1 cycle mid-run -> all outputs 0, prio=0; reads of r0..r3 after CLEAR return 0000.
//  2. req0 write r3=52df; next cycle req1 read r3 -> rsp0 ack rdata=52df, then rsp1 rdata=52df one cycle after accept.
//  3. Contested writes:
//     - Both write: req0 r0=c6d6, req1 r1=7953 -> req0 granted, req1 ready=0; req1 granted next cycle; prio=1.
//     - Repeat the contest -> req1 wins first.
//  4. Same cycle: req0 write r2=93b5, req1 read r2 (r2=0000) -> rsp1 rdata=0000 (macro off) / 93b5 (RF_ARB_FWD_EN).
//  5. Regs hold 8c19/c505/93b5/51ed; pulse clr_start -> clr_busy high 4 cycles, rf_addr3 0,1,2,3, readies 0;
//     afterwards every read returns 0000.
//  6. Reset asserted in the 2nd CLEAR cycle -> clr_busy=0 and rf_write=0 immediately; clr_start afterwards restarts at addr 0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared sizes, FSM state enum and register index type for the RF port arbiter
package rf_arb_pkg;
  localparam int WORD_SIZE = 16;
  localparam int NUM_REG = 4;
  localparam int ADDR_W = $clog2(NUM_REG);
  typedef enum logic {ST_RUN, ST_CLEAR} arb_state_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [WORD_SIZE-1:0] word_t;
endpackage

// File: rtl/rf_arb_rr_pick.sv
// rf_arb_rr_pick: 2-way round-robin write grant (in: want[1:0], prio; out: gnt[1:0], prio_next toggling only on a contest)
module rf_arb_rr_pick (
  input  logic [1:0] want,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       prio_next
);
  always_comb begin
    gnt = &want ? (prio ? 2'b10 : 2'b01) : want;
    prio_next = &want ? ~prio : prio;
  end
endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares 1W/2R register file between req0/req1 (rr write grant, registered rsp, CLEAR sweep via clr_start/clr_busy, rf_* to RF; RF_ARB_FWD_EN adds write-to-read forwarding)
module rf_port_arbiter
  import rf_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [WORD_SIZE-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [WORD_SIZE-1:0] req1_wdata,
  output logic                 rsp0_valid,
  output logic [WORD_SIZE-1:0] rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [WORD_SIZE-1:0] rsp1_rdata,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 rf_write,
  output logic [ADDR_W-1:0]    rf_addr1,
  output logic [ADDR_W-1:0]    rf_addr2,
  output logic [ADDR_W-1:0]    rf_addr3,
  input  logic [WORD_SIZE-1:0] rf_data1,
  input  logic [WORD_SIZE-1:0] rf_data2,
  output logic [WORD_SIZE-1:0] rf_data3
);
  arb_state_t state_q, state_d;
  reg_idx_t clr_cnt_q, clr_cnt_d;
  logic prio_q, prio_d, prio_next;
  logic rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  word_t rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
  logic run, last, acc0, acc1;
  logic [1:0] want, gnt;
  word_t rd0, rd1;
  rf_arb_rr_pick u_pick (
    .want      (want),
    .prio      (prio_q),
    .gnt       (gnt),
    .prio_next (prio_next)
  );
  always_comb begin
    run = state_q == ST_RUN;
    clr_busy = state_q == ST_CLEAR;
    last = clr_cnt_q == reg_idx_t'(NUM_REG - 1);
    want = run ? {req1_valid && req1_we, req0_valid && req0_we} : 2'b00;
    req0_ready = run && (!req0_we || gnt[0]);
    req1_ready = run && (!req1_we || gnt[1]);
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    rf_addr1 = req0_addr;
    rf_addr2 = req1_addr;
    // reset also masks the live write-port drive, not just the registered state
    rf_write = !reset && (clr_busy || |gnt);
    rf_addr3 = reset ? '0 : clr_busy ? clr_cnt_q : gnt[1] ? req1_addr : gnt[0] ? req0_addr : '0;
    rf_data3 = (reset || clr_busy) ? '0 : gnt[1] ? req1_wdata : gnt[0] ? req0_wdata : '0;
`ifdef RF_ARB_FWD_EN
    rd0 = (gnt[1] && req1_addr == req0_addr) ? req1_wdata : rf_data1;
    rd1 = (gnt[0] && req0_addr == req1_addr) ? req0_wdata : rf_data2;
`else
    rd0 = rf_data1;
    rd1 = rf_data2;
`endif
    rsp0_valid_d = acc0;
    rsp1_valid_d = acc1;
    rsp0_rdata_d = acc0 ? (req0_we ? req0_wdata : rd0) : rsp0_rdata_q;
    rsp1_rdata_d = acc1 ? (req1_we ? req1_wdata : rd1) : rsp1_rdata_q;
    prio_d = prio_next;
    state_d = run ? (clr_start ? ST_CLEAR : ST_RUN) : (last ? ST_RUN : ST_CLEAR);
    clr_cnt_d = (clr_busy && !last) ? clr_cnt_q + reg_idx_t'(1) : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      clr_cnt_q <= '0;
      prio_q <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      prio_q <= prio_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
endmodule
